// File: rtl/widener_pkg.sv
// Shared types and constants for the 16-to-64 bus widener.
// Optional read buffer is enabled with the WIDENER_RDBUF_EN macro.
package widener_pkg;

    localparam int   LINE_OFF_W = 3;
    localparam logic SIZ_BYTE   = 1'b0;
    localparam logic SIZ_HALF   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/widener_lanes.sv
// Combinational lane logic: byte selects, write replication, read extraction.
module widener_lanes
    import widener_pkg::*;
(
    input  logic [LINE_OFF_W-1:0] off_i,
    input  logic                  siz_i,
    input  logic                  sgn_i,
    input  logic [15:0]           wdat_i,
    input  logic [63:0]           rdat_i,
    output logic [7:0]            sel_o,
    output logic [63:0]           wdat_o,
    output logic [15:0]           rdat_o
);

    logic [15:0] shifted;

    always_comb begin
        // Halfwords are aligned, so the byte shift also lands them at [15:0].
        shifted = 16'(rdat_i >> {off_i, 3'b000});
        if (siz_i == SIZ_HALF) begin
            sel_o  = 8'b0000_0011 << {off_i[2:1], 1'b0};
            wdat_o = {4{wdat_i}};
            rdat_o = shifted;
        end else begin
            sel_o  = 8'b0000_0001 << off_i;
            wdat_o = {8{wdat_i[7:0]}};
            rdat_o = {{8{sgn_i & shifted[7]}}, shifted[7:0]};
        end
    end

endmodule

// File: rtl/widener.sv
// Narrow (16-bit) to wide (64-bit) bus bridge with optional one-line read buffer.
// Read buffer is present only when WIDENER_RDBUF_EN is defined.
module widener
    import widener_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] m_adr_i,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic        m_siz_i,
    input  logic        m_signed_i,
    input  logic [15:0] m_dat_i,
    output logic        m_ack_o,
    output logic [15:0] m_dat_o,
    output logic        m_err_align_o,
    output logic [63:0] s_adr_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [7:0]  s_sel_o,
    output logic [63:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [63:0] s_dat_i
);

    state_e                state_q, state_d;
    logic [63:0]           s_adr_q, s_adr_d;
    logic [LINE_OFF_W-1:0] off_q, off_d;
    logic                  siz_q, siz_d;
    logic                  sgn_q, sgn_d;
    logic                  s_cyc_q, s_cyc_d;
    logic                  s_stb_q, s_stb_d;
    logic                  s_we_q, s_we_d;
    logic [7:0]            s_sel_q, s_sel_d;
    logic [63:0]           s_dat_q, s_dat_d;
    logic                  m_ack_q, m_ack_d;
    logic [15:0]           m_dat_q, m_dat_d;

    logic                  req_ok, hit, in_bus, bus_done;
    logic [LINE_OFF_W-1:0] lane_off;
    logic                  lane_siz, lane_sgn;
    logic [63:0]           lane_rdat, buf_rdat, lane_wdat;
    logic [7:0]            lane_sel;
    logic [15:0]           lane_rd16;

    assign m_err_align_o = m_cyc_i & m_stb_i & (m_siz_i == SIZ_HALF) & m_adr_i[0];
    assign req_ok        = m_cyc_i & m_stb_i & ~m_err_align_o;
    assign in_bus        = (state_q == BUS);
    assign bus_done      = in_bus & m_cyc_i & s_ack_i;

    // In BUS the lanes decode the latched request; otherwise the live one.
    assign lane_off  = in_bus ? off_q : m_adr_i[LINE_OFF_W-1:0];
    assign lane_siz  = in_bus ? siz_q : m_siz_i;
    assign lane_sgn  = in_bus ? sgn_q : m_signed_i;
    assign lane_rdat = in_bus ? s_dat_i : buf_rdat;

    widener_lanes u_lanes (
        .off_i  (lane_off),
        .siz_i  (lane_siz),
        .sgn_i  (lane_sgn),
        .wdat_i (m_dat_i),
        .rdat_i (lane_rdat),
        .sel_o  (lane_sel),
        .wdat_o (lane_wdat),
        .rdat_o (lane_rd16)
    );

`ifdef WIDENER_RDBUF_EN
    logic        buf_vld_q, buf_vld_d;
    logic [63:3] buf_tag_q, buf_tag_d;
    logic [63:0] buf_dat_q, buf_dat_d;

    assign hit      = ~m_we_i & buf_vld_q & (buf_tag_q == m_adr_i[63:3]);
    assign buf_rdat = buf_dat_q;

    always_comb begin
        buf_vld_d = buf_vld_q;
        buf_tag_d = buf_tag_q;
        buf_dat_d = buf_dat_q;
        if (bus_done) begin
            if (!s_we_q) begin
                buf_vld_d = 1'b1;
                buf_tag_d = s_adr_q[63:3];
                buf_dat_d = s_dat_i;
            end else if (buf_vld_q && (buf_tag_q == s_adr_q[63:3])) begin
                // Write-through: keep the buffered line coherent with the wide side.
                for (int i = 0; i < 8; i++) begin
                    if (s_sel_q[i]) buf_dat_d[8*i +: 8] = s_dat_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            buf_vld_q <= 1'b0;
            buf_tag_q <= '0;
            buf_dat_q <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            buf_tag_q <= buf_tag_d;
            buf_dat_q <= buf_dat_d;
        end
    end
`else
    assign hit      = 1'b0;
    assign buf_rdat = s_dat_i;
`endif

    always_comb begin
        state_d = state_q;
        s_adr_d = s_adr_q;
        off_d   = off_q;
        siz_d   = siz_q;
        sgn_d   = sgn_q;
        s_cyc_d = s_cyc_q;
        s_stb_d = s_stb_q;
        s_we_d  = s_we_q;
        s_sel_d = s_sel_q;
        s_dat_d = s_dat_q;
        m_dat_d = m_dat_q;
        m_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (hit) begin
                        m_dat_d = lane_rd16;
                        m_ack_d = 1'b1;
                        state_d = ACK;
                    end else begin
                        s_adr_d = {m_adr_i[63:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
                        off_d   = m_adr_i[LINE_OFF_W-1:0];
                        siz_d   = m_siz_i;
                        sgn_d   = m_signed_i;
                        s_we_d  = m_we_i;
                        s_sel_d = lane_sel;
                        s_dat_d = lane_wdat;
                        s_cyc_d = 1'b1;
                        s_stb_d = 1'b1;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                // Abort wins over a coincident wide ack.
                if (!m_cyc_i) begin
                    s_cyc_d = 1'b0;
                    s_stb_d = 1'b0;
                    state_d = IDLE;
                end else if (s_ack_i) begin
                    s_cyc_d = 1'b0;
                    s_stb_d = 1'b0;
                    if (!s_we_q) m_dat_d = lane_rd16;
                    m_ack_d = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            s_adr_q <= '0;
            off_q   <= '0;
            siz_q   <= 1'b0;
            sgn_q   <= 1'b0;
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            s_we_q  <= 1'b0;
            s_sel_q <= '0;
            s_dat_q <= '0;
            m_ack_q <= 1'b0;
            m_dat_q <= '0;
        end else begin
            state_q <= state_d;
            s_adr_q <= s_adr_d;
            off_q   <= off_d;
            siz_q   <= siz_d;
            sgn_q   <= sgn_d;
            s_cyc_q <= s_cyc_d;
            s_stb_q <= s_stb_d;
            s_we_q  <= s_we_d;
            s_sel_q <= s_sel_d;
            s_dat_q <= s_dat_d;
            m_ack_q <= m_ack_d;
            m_dat_q <= m_dat_d;
        end
    end

    assign m_ack_o = m_ack_q;
    assign m_dat_o = m_dat_q;
    assign s_adr_o = s_adr_q;
    assign s_cyc_o = s_cyc_q;
    assign s_stb_o = s_stb_q;
    assign s_we_o  = s_we_q;
    assign s_sel_o = s_sel_q;
    assign s_dat_o = s_dat_q;

endmodule
